// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its tag FIFO.
package fetch_pkg;

    localparam int unsigned PC_STEP      = 4;
    // Tags carry a fixed-width PC so the FIFO type is independent of ADDR_WIDTH.
    localparam int unsigned TAG_PC_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [TAG_PC_WIDTH-1:0] pc;
        logic                    epoch;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_tag_fifo.sv
// Small synchronous FIFO holding the {pc, epoch} tag of every in-flight IMEM request.
module fetch_tag_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             push_i,
    input  fetch_tag_t       tag_i,
    input  logic             pop_i,
    output fetch_tag_t       tag_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_tag_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign tag_o   = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential PCs to IMEM, tags them with an epoch,
// and forwards non-stale responses to decode as a registered packet.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH      = 32,
    parameter int unsigned          DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned          MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  fetch_enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid_out,
    input  logic                  pc_ready_in,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instruction_valid_in,
    output logic                  instruction_ready_out,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [DATA_WIDTH-1:0] fetch_instruction,
    output logic                  fetch_valid_out,
    input  logic                  fetch_ready_in
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  epoch_q, epoch_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
    logic                  fetch_valid_q, fetch_valid_d;

    fetch_tag_t            push_tag;
    fetch_tag_t            head_tag;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  req_hs;
    logic                  resp_hs;
    logic                  head_stale;
    logic                  deliver;
    logic                  unused_bits;

    assign push_tag   = '{pc: TAG_PC_WIDTH'(pc_q), epoch: epoch_q};
    assign head_pc    = head_tag.pc[ADDR_WIDTH-1:0];
    assign head_stale = (head_tag.epoch != epoch_q);

    assign pc_valid_out = sync_rst_n && (state_q == ST_RUN) && (fifo_count != CNT_W'(MAX_OUTSTANDING));
    // Stale heads are always drained so a stalled decode never blocks recovery after a redirect.
    assign instruction_ready_out = sync_rst_n && !fifo_empty &&
                                   (head_stale || !fetch_valid_q || fetch_ready_in);
    assign req_hs  = pc_valid_out && pc_ready_in;
    assign resp_hs = instruction_valid_in && instruction_ready_out;
    assign deliver = resp_hs && !head_stale && !redirect_valid;

    fetch_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .push_i     (req_hs),
        .tag_i      (push_tag),
        .pop_i      (resp_hs),
        .tag_o      (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        pc_d          = pc_q;
        epoch_d       = epoch_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        fetch_valid_d = fetch_valid_q;
        if (redirect_valid) begin
            epoch_d       = ~epoch_q;
            pc_d          = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            fetch_valid_d = 1'b0;
        end else begin
            if (req_hs) begin
                pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
            end
            if (deliver) begin
                fetch_pc_d    = head_pc;
                fetch_instr_d = instruction;
                fetch_valid_d = 1'b1;
            end else if (fetch_valid_q && fetch_ready_in) begin
                fetch_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            epoch_q       <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_instr_q <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_BOOT:  state_q <= fetch_enable ? ST_RUN : ST_PAUSE;
                ST_RUN:   if (!fetch_enable) state_q <= ST_PAUSE;
                ST_PAUSE: if (fetch_enable) state_q <= ST_RUN;
                default:  state_q <= ST_BOOT;
            endcase
            pc_q          <= pc_d;
            epoch_q       <= epoch_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign pc                = pc_q;
    assign fetch_pc          = fetch_pc_q;
    assign fetch_instruction = fetch_instr_q;
    assign fetch_valid_out   = fetch_valid_q;

    assign unused_bits = ^{redirect_pc[1:0], head_tag.pc, fifo_full};

    // A response with nothing outstanding means IMEM broke the protocol.
    a_no_orphan_response: assert property (@(posedge clk) disable iff (!sync_rst_n)
        !(instruction_valid_in && fifo_empty))
        else $error("fetch_unit: IMEM response with no outstanding request");

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected packets queued at request time, checked by a monitor.
module tb_fetch_unit;

    localparam int MAXO = 2;

    typedef struct {
        logic [31:0] addr;
        int          gen;
    } imem_ent_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_rst_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic        pc_valid_out;
    logic        pc_ready_in = 1'b0;
    logic [31:0] instruction = '0;
    logic        instruction_valid_in = 1'b0;
    logic        instruction_ready_out;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        fetch_valid_out;
    logic        fetch_ready_in = 1'b0;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(pc), .pc_valid_out(pc_valid_out), .pc_ready_in(pc_ready_in),
        .instruction(instruction), .instruction_valid_in(instruction_valid_in),
        .instruction_ready_out(instruction_ready_out),
        .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
        .fetch_valid_out(fetch_valid_out), .fetch_ready_in(fetch_ready_in)
    );

    // Second instance checks PC wrap from the top of the address space.
    logic        rst2_n = 1'b0;
    logic [31:0] pc2, instr2 = '0, fpc2, finstr2;
    logic        pcv2, iv2 = 1'b0, irdy2, fv2;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .MAX_OUTSTANDING(MAXO)) dut2 (
        .clk(clk), .sync_rst_n(rst2_n), .fetch_enable(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .pc(pc2), .pc_valid_out(pcv2), .pc_ready_in(1'b1),
        .instruction(instr2), .instruction_valid_in(iv2),
        .instruction_ready_out(irdy2),
        .fetch_pc(fpc2), .fetch_instruction(finstr2),
        .fetch_valid_out(fv2), .fetch_ready_in(1'b1)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    imem_ent_t   imem_q[$];
    logic [31:0] model_pc = '0;
    int          cur_gen = 0;
    bit          resp_hold = 0;
    int          delivered = 0;
    bit          want_rst_n = 0, want_en = 0, force_frdy_low = 0;
    int          pc_rdy_pct = 100, resp_pct = 100, frdy_pct = 100;
    bit          cap_armed = 0, cap_valid = 0;
    logic [31:0] cap_pc = '0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit no_stale();
        foreach (imem_q[i]) if (imem_q[i].gen != cur_gen) return 0;
        return 1;
    endfunction

    // One clock: drive at negedge, then update the reference model for the coming edge.
    task automatic cycle(input bit redir = 0, input logic [31:0] tgt = '0);
        bit req_hs, resp_hs;
        int outstanding;
        @(negedge clk);
        sync_rst_n     = want_rst_n;
        fetch_enable   = want_en;
        redirect_valid = redir;
        redirect_pc    = tgt;
        pc_ready_in    = ($urandom_range(99) < pc_rdy_pct);
        fetch_ready_in = !force_frdy_low && ($urandom_range(99) < frdy_pct);
        if (imem_q.size() == 0) resp_hold = 0;
        else if (!resp_hold && $urandom_range(99) < resp_pct) resp_hold = 1;
        instruction_valid_in = resp_hold;
        instruction = (imem_q.size() > 0) ? mem_f(imem_q[0].addr) : 32'h0;
        #2;
        if (!sync_rst_n) begin
            exp_q.delete();
            imem_q.delete();
            resp_hold = 0;
            model_pc  = 32'h0;
            return;
        end
        req_hs      = pc_valid_out && pc_ready_in;
        resp_hs     = instruction_valid_in && instruction_ready_out;
        outstanding = imem_q.size();
        if (resp_hs) begin
            void'(imem_q.pop_front());
            resp_hold = 0;
        end
        if (req_hs) begin
            check("req_pc", pc, model_pc);
            check("outstanding_limit", 32'(outstanding < MAXO), 32'd1);
            imem_q.push_back('{addr: pc, gen: cur_gen});
        end
        if (redir) begin
            exp_q.delete();
            model_pc  = {tgt[31:2], 2'b00};
            cur_gen++;
            cap_armed = 1;
            cap_valid = 0;
        end else if (req_hs) begin
            exp_q.push_back(model_pc);
            model_pc += 32'd4;
        end
    endtask

    // Monitor: pops the scoreboard on every decode handshake and checks held packets stay put.
    bit          hold_chk = 0;
    logic [31:0] held_pc, held_ins, mon_e;
    always @(negedge clk) begin
        #1;
        if (sync_rst_n) begin
            if (hold_chk) begin
                check("hold_valid", fetch_valid_out, 1'b1);
                check("hold_pc", fetch_pc, held_pc);
                check("hold_instr", fetch_instruction, held_ins);
            end
            hold_chk = 0;
            if (fetch_valid_out && fetch_ready_in) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL deliver_unexpected: got pc %h expected no packet", fetch_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("deliver_pc", fetch_pc, mon_e);
                    check("deliver_instr", fetch_instruction, mem_f(mon_e));
                end
                if (cap_armed) begin
                    cap_pc    = fetch_pc;
                    cap_valid = 1;
                    cap_armed = 0;
                end
                delivered++;
            end else if (fetch_valid_out && !redirect_valid) begin
                hold_chk = 1;
                held_pc  = fetch_pc;
                held_ins = fetch_instruction;
            end
        end else begin
            hold_chk = 0;
        end
    end

    // Wrap-around instance driver: ideal 1-cycle IMEM, decode always ready.
    initial begin : wrap_test
        bit          last_hs = 0;
        logic [31:0] last_pc = '0;
        logic [31:0] got[2];
        int          n = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst2_n = 1'b1;
            iv2    = last_hs;
            instr2 = mem_f(last_pc);
            #1;
            last_hs = pcv2;
            last_pc = pc2;
            if (fv2 && n < 2) begin
                got[n] = fpc2;
                n++;
            end
        end
        check("wrap_count", n, 2);
        if (n == 2) begin
            check("wrap_pc0", got[0], 32'hFFFF_FFFC);
            check("wrap_pc1", got[1], 32'h0000_0000);
        end
    end

    initial begin : main
        int lat;
        int d0;
        repeat (3) cycle();
        check("rst_fetch_valid", fetch_valid_out, 1'b0);
        check("rst_fetch_pc", fetch_pc, 32'h0);
        check("rst_fetch_instr", fetch_instruction, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_valid", pc_valid_out, 1'b0);
        check("rst_instr_ready", instruction_ready_out, 1'b0);

        want_rst_n = 1;
        want_en    = 1;
        lat        = 0;
        do begin
            cycle();
            lat++;
        end while (!fetch_valid_out && lat < 20);
        check("first_valid_latency", lat - 1, 3);
        check("first_pc", fetch_pc, 32'h0);

        cycle();
        force_frdy_low = 1;
        repeat (5) cycle();
        check("stall_held_pc", fetch_pc, 32'h8);
        check("stall_held_valid", fetch_valid_out, 1'b1);
        check("stall_no_request", pc_valid_out, 1'b0);
        force_frdy_low = 0;
        repeat (2) cycle();
        d0 = delivered;
        repeat (20) cycle();
        check("throughput", delivered - d0, 20);

        resp_pct = 0;
        repeat (3) cycle();
        check("two_in_flight", imem_q.size(), 2);
        cycle(1'b1, 32'h103);
        resp_pct = 100;
        repeat (10) cycle();
        check("redir_cap_valid", cap_valid, 1'b1);
        check("redir_first_pc", cap_pc, 32'h100);

        cycle(1'b1, 32'h200);
        repeat (10) cycle();
        check("coincident_redir_pc", cap_pc, 32'h200);

        want_en = 0;
        repeat (2) cycle();
        check("pause_no_request", pc_valid_out, 1'b0);
        repeat (6) cycle();
        check("pause_inflight_delivered", exp_q.size(), 0);
        want_en = 1;

        pc_rdy_pct = 60;
        resp_pct   = 60;
        frdy_pct   = 60;
        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = ($urandom_range(99) < 4) && no_stale();
            if ($urandom_range(99) < 5) want_en = !want_en;
            cycle(r, $urandom());
        end

        want_rst_n = 0;
        repeat (2) cycle();
        check("midrst_fetch_valid", fetch_valid_out, 1'b0);
        check("midrst_fetch_pc", fetch_pc, 32'h0);
        check("midrst_fetch_instr", fetch_instruction, 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_pc_valid", pc_valid_out, 1'b0);
        want_rst_n = 1;
        want_en    = 1;
        for (int i = 0; i < 300; i++) cycle();

        want_en    = 0;
        pc_rdy_pct = 100;
        resp_pct   = 100;
        frdy_pct   = 100;
        repeat (20) cycle();
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_imem_empty", imem_q.size(), 0);
        check("drain_fetch_idle", fetch_valid_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
